mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 117 +++++++++++
 tb/tb_mem_copy_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-oriented memory copy / fill engine.
// A copy costs one read and one write per word; a fill costs one write.
module mem_copy_engine #(
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            fill,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  input  logic [31:0]     fill_value,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [LENW-1:0] words_done,
  output logic            mem_wr,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_writedata,
  input  logic [31:0]     mem_readdata
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, FILLW, DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     src;
  logic [31:0]     dst;
  logic [31:0]     fval;
  logic [31:0]     data;
  logic [LENW-1:0] cnt;
  logic            last;

  assign last = (cnt == LENW'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      fval       <= '0;
      data       <= '0;
      cnt        <= '0;
      words_done <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            // addresses are word-aligned
            src        <= src_addr & 32'hFFFF_FFFC;
            dst        <= dst_addr & 32'hFFFF_FFFC;
            fval       <= fill_value;
            cnt        <= len;
            words_done <= '0;
          end
        end
        READ: data <= mem_readdata;
        WRITE: begin
          src        <= src + 32'd4;
          dst        <= dst + 32'd4;
          cnt        <= cnt - LENW'(1);
          words_done <= words_done + LENW'(1);
        end
        FILLW: begin
          dst        <= dst + 32'd4;
          cnt        <= cnt - LENW'(1);
          words_done <= words_done + LENW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (len == '0) ? DONE :
                      (fill ? FILLW : READ);
      end
      READ: begin
        busy      = 1'b1;
        mem_addr  = src;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy          = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = dst;
        mem_writedata = data;
        state_nxt     = last ? DONE : READ;
      end
      FILLW: begin
        busy          = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = dst;
        mem_writedata = fval;
        state_nxt     = last ? DONE : FILLW;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: per-cycle trace model plus
// hand-computed expectations for the directed scenarios.
module tb_mem_copy_engine;

  localparam int LENW = 8;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic            fill;
  logic [31:0]     src_addr;
  logic [31:0]     dst_addr;
  logic [31:0]     fill_value;
  logic [LENW-1:0] len;
  logic            busy;
  logic            done;
  logic [LENW-1:0] words_done;
  logic            mem_wr;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_writedata;
  logic [31:0]     mem_readdata;

  mem_copy_engine #(.LENW(LENW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .fill          (fill),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .fill_value    (fill_value),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .words_done    (words_done),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench data memory, 256 words, indexed by address bits [9:2]
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        mem_load;

  assign mem_readdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd11;
      mem[1] <= 32'd22;
      mem[2] <= 32'd33;
      mem[3] <= 32'd44;
    end else if (mem_wr) begin
      mem[mem_addr[9:2]] <= mem_writedata;
    end
  end

  typedef struct {
    logic        busy;
    logic        done;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];
  int          n_run;
  int          n_fail;
  int          cyc;
  int          t0;
  int          done_cyc;
  bit          busy_seen;
  bit          chk_en;
  logic [7:0]  last_wd;

  function automatic exp_t mk(input logic b, input logic dn,
                              input logic w, input logic [31:0] a,
                              input logic [31:0] dt,
                              input logic [7:0] wd);
    exp_t e;
    e.busy = b;
    e.done = dn;
    e.wr   = w;
    e.addr = a;
    e.data = dt;
    e.wd   = wd;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Expected bus trace of one operation, word by word.
  task automatic build(input bit f, input logic [31:0] s,
                       input logic [31:0] d, input logic [31:0] v,
                       input logic [7:0] n, output exp_t q[$]);
    logic [31:0] m [256];
    logic [31:0] sa;
    logic [31:0] da;
    logic [31:0] w;
    m = ref_mem;
    s = s & ~32'h3;
    d = d & ~32'h3;
    q = {};
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      if (f) begin
        w = v;
      end else begin
        w = m[sa[9:2]];
        q.push_back(mk(1'b1, 1'b0, 1'b0, sa, 32'd0, 8'(i)));
      end
      m[da[9:2]] = w;
      q.push_back(mk(1'b1, 1'b0, 1'b1, da, w, 8'(i)));
    end
    q.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, n));
  endtask

  task automatic push_q(input exp_t q[$], input int lim);
    for (int i = 0; i < q.size(); i++) begin
      if (lim >= 0 && i >= lim) break;
      if (q[i].wr) ref_mem[q[i].addr[9:2]] = q[i].data;
      exp_q.push_back(q[i]);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    done_cyc  = -1;
    busy_seen = 1'b0;
  endtask

  // called at negedge+1; start is sampled at the next rising edge
  task automatic launch(input bit f, input logic [31:0] s,
                        input logic [31:0] d, input logic [31:0] v,
                        input logic [7:0] n, input int lim);
    exp_t q[$];
    build(f, s, d, v, n, q);
    push_q(q, lim);
    fill       = f;
    src_addr   = s;
    dst_addr   = d;
    fill_value = v;
    len        = n;
    start      = 1'b1;
    clear_logs();
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout: %0d trace cycles left", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_wd = e.wd;
      end else begin
        e = mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, last_wd);
      end
      n_run++;
      if (busy !== e.busy || done !== e.done || mem_wr !== e.wr ||
          words_done !== e.wd || mem_addr !== e.addr ||
          ((e.wr || !e.busy) && mem_writedata !== e.data)) begin
        n_fail++;
        $display("FAIL cycle %0d: busy/done/wr/addr/data/wd got %b %b %b %h %h %0d want %b %b %b %h %h %0d",
                 cyc, busy, done, mem_wr, mem_addr, mem_writedata,
                 words_done, e.busy, e.done, e.wr, e.addr, e.data, e.wd);
      end
      if (mem_wr) wr_log.push_back(mem_addr);
      if (busy && !mem_wr) rd_log.push_back(mem_addr);
      if (busy) busy_seen = 1'b1;
      if (done && done_cyc < 0) done_cyc = cyc - t0;
    end
  end

  initial begin
    exp_t q[$];
    int   diffs;
    n_run      = 0;
    n_fail     = 0;
    cyc        = 0;
    t0         = 0;
    chk_en     = 1'b0;
    last_wd    = 8'd0;
    mem_load   = 1'b1;
    reset_n    = 1'b0;
    start      = 1'b0;
    fill       = 1'b0;
    src_addr   = 32'd0;
    dst_addr   = 32'd0;
    fill_value = 32'd0;
    len        = '0;
    clear_logs();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    ref_mem[0] = 32'd11;
    ref_mem[1] = 32'd22;
    ref_mem[2] = 32'd33;
    ref_mem[3] = 32'd44;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    mem_load = 1'b0;
    reset_n  = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wr", 32'(mem_wr), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wd", 32'(words_done), 32'd0);
    chk_en = 1'b1;

    // copy 4 words 0x0 -> 0x40
    launch(1'b0, 32'h0, 32'h40, 32'h0, 8'd4, -1);
    wait_idle();
    check("copy_done_cycle", 32'(done_cyc), 32'd9);
    check("copy_words_done", 32'(words_done), 32'd4);
    check("copy_nwrites", 32'(wr_log.size()), 32'd4);
    check("copy_first_wr", wr_log[0], 32'h40);
    check("copy_last_wr", wr_log[3], 32'h4C);
    check("copy_mem16", mem[16], 32'd11);
    check("copy_mem19", mem[19], 32'd44);

    // fill 3 words at 0x20
    launch(1'b1, 32'h0, 32'h20, 32'hDEADBEEF, 8'd3, -1);
    wait_idle();
    check("fill_done_cycle", 32'(done_cyc), 32'd4);
    check("fill_nwrites", 32'(wr_log.size()), 32'd3);
    check("fill_wr0", wr_log[0], 32'h20);
    check("fill_wr2", wr_log[2], 32'h28);
    check("fill_mem10", mem[10], 32'hDEADBEEF);

    // zero-length operation
    launch(1'b0, 32'h0, 32'h40, 32'h0, 8'd0, -1);
    wait_idle();
    check("len0_done_cycle", 32'(done_cyc), 32'd1);
    check("len0_nwrites", 32'(wr_log.size()), 32'd0);
    check("len0_busy_seen", 32'(busy_seen), 32'd0);

    // start held high: exactly one op, next one from the IDLE cycle
    build(1'b0, 32'h0, 32'h60, 32'h0, 8'd2, q);
    push_q(q, -1);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd2));
    build(1'b0, 32'h0, 32'h60, 32'h0, 8'd2, q);
    push_q(q, -1);
    fill     = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h60;
    len      = 8'd2;
    start    = 1'b1;
    clear_logs();
    t0 = cyc;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("held_done_cycle", 32'(done_cyc), 32'd5);
    check("held_nwrites", 32'(wr_log.size()), 32'd4);

    // reset during the second WRITE of a 4-word copy
    launch(1'b0, 32'h0, 32'h80, 32'h0, 8'd4, 4);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle();
    check("rst_nwrites", 32'(wr_log.size()), 32'd2);
    check("rst_words_done", 32'(words_done), 32'd0);
    check("rst_mem33", mem[33], 32'd22);
    check("rst_mem34", mem[34], 32'd0);

    // unaligned addresses are truncated to word boundaries
    launch(1'b0, 32'h3, 32'h11, 32'h0, 8'd1, -1);
    wait_idle();
    check("align_rd", rd_log[0], 32'h0);
    check("align_wr", wr_log[0], 32'h10);
    check("align_mem4", mem[4], 32'd11);

    // overlapping copy, dst above src, ascending order
    launch(1'b0, 32'h0, 32'h4, 32'h0, 8'd3, -1);
    wait_idle();
    check("ovl_mem2", mem[2], 32'd11);
    check("ovl_mem3", mem[3], 32'd11);

    // address wrap at 2^32
    launch(1'b1, 32'h0, 32'hFFFF_FFF8, 32'h5A5A_5A5A, 8'd3, -1);
    wait_idle();
    check("wrap_wr1", wr_log[1], 32'hFFFF_FFFC);
    check("wrap_wr2", wr_log[2], 32'h0);

    // maximum length fill
    launch(1'b1, 32'h0, 32'h100, 32'h77, 8'hFF, -1);
    wait_idle();
    check("max_words_done", 32'(words_done), 32'd255);
    check("max_done_cycle", 32'(done_cyc), 32'd256);
    check("max_nwrites", 32'(wr_log.size()), 32'd255);

    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
